// File: rtl/coproc_pkg.sv
// coproc_pkg: shared encodings for the block address sequencer
package coproc_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, EMIT, FINISH} state_t;
   localparam logic [2:0] TYPE_A = 3'b001;
   localparam logic [2:0] TYPE_B = 3'b010;
   localparam logic [2:0] TYPE_C = 3'b100;
   localparam int LAMBDA_LSB = 0;
   localparam int GAMMA_LSB = 8;
   localparam int MU_LSB = 16;
endpackage

// File: rtl/block_addr_calc.sv
// block_addr_calc: combinational block (row, col) to word address translation
module block_addr_calc
   import coproc_pkg::*;
#(
   parameter int INDEX_WIDTH = 8,
   parameter int K = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int A_BASE = 2,
   parameter int OUT_BASE = 512
) (
   input  logic [2:0]             blk_type,
   input  logic [INDEX_WIDTH-1:0] row,
   input  logic [INDEX_WIDTH-1:0] col,
   input  logic [INDEX_WIDTH-1:0] mu,
   input  logic [INDEX_WIDTH-1:0] gamma,
   input  logic [ADDR_WIDTH-1:0]  b_base,
   output logic [ADDR_WIDTH-1:0]  addr
);
   localparam int FW = 2 * INDEX_WIDTH + $clog2(K * K) + ADDR_WIDTH + 1;
   logic [FW-1:0] stride, base, offset;
   // wide intermediates, single truncation at the end gives modulo 2^ADDR_WIDTH
   always_comb begin
      stride = FW'(blk_type == TYPE_A ? mu : gamma);
      base = blk_type == TYPE_A ? FW'(A_BASE) : blk_type == TYPE_B ? FW'(b_base) : FW'(OUT_BASE);
      offset = (FW'(row) * stride + FW'(col)) * FW'(K * K);
      addr = ADDR_WIDTH'(base + offset);
   end
endmodule

// File: rtl/block_address_sequencer.sv
// block_address_sequencer: walks all block operations of C = A x B and streams operand/output block addresses
module block_address_sequencer
   import coproc_pkg::*;
#(
   parameter int INDEX_WIDTH = 8,
   parameter int K = 2,
   parameter int ADDR_WIDTH = 10,
   parameter int A_BASE = 2,
   parameter int OUT_BASE = 512
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset_n,
   input  logic [31:0]            i_Config,
   input  logic                   i_Start,
   input  logic                   i_Abort,
   input  logic                   i_Addr_Ready,
   output logic                   o_Addr_Valid,
   output logic [ADDR_WIDTH-1:0]  o_Address,
   output logic [2:0]             o_Type,
   output logic [INDEX_WIDTH-1:0] o_Row_Index,
   output logic [INDEX_WIDTH-1:0] o_Col_Index,
   output logic                   o_Last,
   output logic                   o_Busy,
   output logic                   o_Done,
   output logic                   o_Error
);
   localparam int FW = 2 * INDEX_WIDTH + $clog2(K * K) + ADDR_WIDTH + 1;
   localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);
   state_t state;
   logic [INDEX_WIDTH-1:0] lam, gam, mu_r, cur_i, cur_j, cur_t;
   logic [INDEX_WIDTH-1:0] n_i, n_j, n_t, n_row, n_col, cfg_lam, cfg_gam, cfg_mu;
   logic [ADDR_WIDTH-1:0] b_base, n_addr;
   logic [2:0] n_type;
   logic n_last, end_t, end_j, dims_zero, advance;
   assign cfg_lam = i_Config[LAMBDA_LSB +: INDEX_WIDTH];
   assign cfg_gam = i_Config[GAMMA_LSB +: INDEX_WIDTH];
   assign cfg_mu = i_Config[MU_LSB +: INDEX_WIDTH];
   assign end_t = cur_t == mu_r - ONE;
   assign end_j = cur_j == gam - ONE;
   assign dims_zero = lam == '0 || gam == '0 || mu_r == '0;
   assign advance = !i_Abort && ((state == LOAD && !dims_zero) ||
                                 (state == EMIT && i_Addr_Ready && !o_Last));
   // successor of the element currently held in the output register
   always_comb begin
      n_type = state == LOAD ? TYPE_A : o_Type == TYPE_A ? TYPE_B :
               o_Type == TYPE_B && end_t ? TYPE_C : TYPE_A;
      n_t = state == LOAD || o_Type == TYPE_C ? '0 : o_Type == TYPE_B && !end_t ? cur_t + ONE : cur_t;
      n_j = state == LOAD || (o_Type == TYPE_C && end_j) ? '0 : o_Type == TYPE_C ? cur_j + ONE : cur_j;
      n_i = state == LOAD ? '0 : o_Type == TYPE_C && end_j ? cur_i + ONE : cur_i;
      n_row = n_type == TYPE_B ? n_t : n_i;
      n_col = n_type == TYPE_A ? n_t : n_j;
      n_last = n_type == TYPE_C && n_i == lam - ONE && n_j == gam - ONE;
   end
   block_addr_calc #(
      .INDEX_WIDTH(INDEX_WIDTH),
      .K(K),
      .ADDR_WIDTH(ADDR_WIDTH),
      .A_BASE(A_BASE),
      .OUT_BASE(OUT_BASE)
   ) u_calc (
      .blk_type(n_type),
      .row(n_row),
      .col(n_col),
      .mu(mu_r),
      .gamma(gam),
      .b_base(b_base),
      .addr(n_addr)
   );
   always_ff @(posedge i_Clock or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         state <= IDLE;
         lam <= '0;
         gam <= '0;
         mu_r <= '0;
         b_base <= '0;
         cur_i <= '0;
         cur_j <= '0;
         cur_t <= '0;
         o_Addr_Valid <= 1'b0;
         o_Address <= '0;
         o_Type <= '0;
         o_Row_Index <= '0;
         o_Col_Index <= '0;
         o_Last <= 1'b0;
         o_Busy <= 1'b0;
         o_Done <= 1'b0;
         o_Error <= 1'b0;
      end else begin
         o_Done <= 1'b0;
         o_Error <= 1'b0;
         if (i_Abort && state != IDLE) begin
            state <= IDLE;
            o_Busy <= 1'b0;
            o_Addr_Valid <= 1'b0;
            o_Last <= 1'b0;
         end else begin
            case (state)
               IDLE: if (i_Start && !i_Abort) begin
                  state <= LOAD;
                  o_Busy <= 1'b1;
                  lam <= cfg_lam;
                  gam <= cfg_gam;
                  mu_r <= cfg_mu;
                  b_base <= ADDR_WIDTH'(FW'(A_BASE) + FW'(cfg_lam) * FW'(cfg_mu) * FW'(K * K));
               end
               LOAD: if (dims_zero) begin
                  state <= FINISH;
                  o_Done <= 1'b1;
                  o_Error <= 1'b1;
               end else state <= EMIT;
               EMIT: if (i_Addr_Ready && o_Last) begin
                  state <= FINISH;
                  o_Addr_Valid <= 1'b0;
                  o_Last <= 1'b0;
                  o_Done <= 1'b1;
               end
               FINISH: begin
                  state <= IDLE;
                  o_Busy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
         if (advance) begin
            o_Addr_Valid <= 1'b1;
            o_Address <= n_addr;
            o_Type <= n_type;
            o_Row_Index <= n_row;
            o_Col_Index <= n_col;
            o_Last <= n_last;
            cur_i <= n_i;
            cur_j <= n_j;
            cur_t <= n_t;
         end
      end
   end
endmodule

// File: tb/tb_block_address_sequencer.sv
// tb_block_address_sequencer: directed self-checking bench for block_address_sequencer
module tb_block_address_sequencer;
   typedef struct packed {
      logic [2:0] ty;
      logic [9:0] a;
      logic [7:0] r;
      logic [7:0] c;
      logic       l;
   } ent_t;
   logic clk = 1'b0;
   logic rst_n, start, abort, ready, sel;
   logic [31:0] cfg;
   logic v1, l1, b1, d1, e1, v2, l2, b2, d2, e2;
   logic [9:0] a1, a2;
   logic [2:0] t1, t2;
   logic [7:0] r1, c1, r2, c2;
   logic sv, sl, sb, sd, se;
   logic [9:0] sa;
   logic [2:0] st;
   logic [7:0] sr, sc;
   ent_t q[$];
   logic [9:0] obs_addr[0:63];
   int n_cmp = 0;
   int n_bad = 0;
   int nx, span;
   always #5 clk = ~clk;
   assign sv = sel ? v2 : v1;
   assign sa = sel ? a2 : a1;
   assign st = sel ? t2 : t1;
   assign sr = sel ? r2 : r1;
   assign sc = sel ? c2 : c1;
   assign sl = sel ? l2 : l1;
   assign sb = sel ? b2 : b1;
   assign sd = sel ? d2 : d1;
   assign se = sel ? e2 : e1;
   block_address_sequencer dut (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Config(cfg), .i_Start(start), .i_Abort(abort),
      .i_Addr_Ready(ready), .o_Addr_Valid(v1), .o_Address(a1), .o_Type(t1), .o_Row_Index(r1),
      .o_Col_Index(c1), .o_Last(l1), .o_Busy(b1), .o_Done(d1), .o_Error(e1)
   );
   block_address_sequencer #(.OUT_BASE(1020)) dut_wrap (
      .i_Clock(clk), .i_Reset_n(rst_n), .i_Config(cfg), .i_Start(start), .i_Abort(abort),
      .i_Addr_Ready(ready), .o_Addr_Valid(v2), .o_Address(a2), .o_Type(t2), .o_Row_Index(r2),
      .o_Col_Index(c2), .o_Last(l2), .o_Busy(b2), .o_Done(d2), .o_Error(e2)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   function automatic logic [63:0] cur_vec();
      return 64'({sv, sa, st, sr, sc, sl});
   endfunction
   function automatic logic [63:0] exp_vec(input ent_t e);
      return 64'({1'b1, e.a, e.ty, e.r, e.c, e.l});
   endfunction
   // expected emission order straight from the address formulas (K=2, A_BASE=2)
   function automatic void build(input int lam, input int mu, input int gam, input int ob);
      int bb = 2 + lam * mu * 4;
      q.delete();
      for (int i = 0; i < lam; i++)
         for (int j = 0; j < gam; j++) begin
            for (int t = 0; t < mu; t++) begin
               q.push_back('{3'b001, 10'(2 + (i * mu + t) * 4), 8'(i), 8'(t), 1'b0});
               q.push_back('{3'b010, 10'(bb + (t * gam + j) * 4), 8'(t), 8'(j), 1'b0});
            end
            q.push_back('{3'b100, 10'(ob + (i * gam + j) * 4), 8'(i), 8'(j), i == lam - 1 && j == gam - 1});
         end
   endfunction
   task automatic start_job(input logic [31:0] c);
      @(negedge clk);
      cfg = c;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cfg = 32'hFFFF_FFFF;
      chk("load_no_valid", 64'(sv), 64'd0);
   endtask
   task automatic run_stream(input int stall_at, input int stall_len, input int stop_at,
                             input bit use_reset, output int n, output int sp);
      int stalled = 0;
      int first = -1;
      bit fin = 1'b0;
      logic [63:0] snap = '0;
      n = 0;
      sp = 0;
      for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
         @(negedge clk);
         ready = !(n == stall_at && stalled < stall_len);
         if (!ready) begin
            if (stalled == 0) snap = cur_vec();
            else chk($sformatf("stall_hold_%0d", stalled), cur_vec(), snap);
            stalled++;
         end else if (sv) begin
            if (first < 0) first = cyc;
            obs_addr[n] = sa;
            if (n < q.size()) chk($sformatf("emit_%0d", n), cur_vec(), exp_vec(q[n]));
            else chk("extra_emit", 64'(n), 64'(q.size()));
            if (sl) begin
               fin = 1'b1;
               sp = cyc - first + 1;
            end
            if (n == stop_at) begin
               fin = 1'b1;
               if (use_reset) begin
                  rst_n = 1'b0;
                  #1;
                  chk("reset_valid_drop", 64'(sv), 64'd0);
               end else abort = 1'b1;
            end
            n++;
         end
      end
      ready = 1'b1;
      chk("stream_complete", 64'(fin), 64'd1);
   endtask
   task automatic finish_chk(input string tag);
      @(negedge clk);
      chk({tag, "_done"}, 64'({sv, sd, se, sb}), 64'b0101);
      @(negedge clk);
      chk({tag, "_idle"}, 64'({sv, sd, se, sb}), 64'b0000);
   endtask
   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      ready = 1'b1;
      sel = 1'b0;
      cfg = '0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 64'({v1, a1, t1, r1, c1, l1, b1, d1, e1}), 64'd0);
      rst_n = 1'b1;
      // single block job
      build(1, 1, 1, 512);
      start_job(32'h0001_0101);
      run_stream(-1, 0, -1, 1'b0, nx, span);
      chk("t1_count", 64'(nx), 64'd3);
      chk("t1_a", 64'(obs_addr[0]), 64'd2);
      chk("t1_b", 64'(obs_addr[1]), 64'd6);
      chk("t1_c", 64'(obs_addr[2]), 64'd512);
      finish_chk("t1");
      // 2x3x2 job at full rate, with start pulses while busy
      build(2, 3, 2, 512);
      start_job(32'h0003_0202);
      start = 1'b1;
      run_stream(-1, 0, -1, 1'b0, nx, span);
      start = 1'b0;
      chk("t2_count", 64'(nx), 64'd28);
      chk("t2_span", 64'(span), 64'd28);
      chk("t2_a_i1j1t2", 64'(obs_addr[25]), 64'd22);
      chk("t2_b_i1j1t2", 64'(obs_addr[26]), 64'd46);
      chk("t2_c_last", 64'(obs_addr[27]), 64'd524);
      finish_chk("t2");
      // same job with backpressure on the 4th emission
      start_job(32'h0003_0202);
      run_stream(3, 5, -1, 1'b0, nx, span);
      chk("t3_count", 64'(nx), 64'd28);
      chk("t3_span", 64'(span), 64'd33);
      finish_chk("t3");
      // zero dimension
      start_job(32'h0000_0102);
      @(negedge clk);
      chk("t4_err_pulse", 64'({sv, sd, se}), 64'b011);
      @(negedge clk);
      chk("t4_idle", 64'({sv, sd, se, sb}), 64'd0);
      // address wrap with OUT_BASE=1020
      sel = 1'b1;
      build(1, 1, 2, 1020);
      start_job(32'h0001_0201);
      run_stream(-1, 0, -1, 1'b0, nx, span);
      chk("t5_count", 64'(nx), 64'd6);
      chk("t5_c00", 64'(obs_addr[2]), 64'd1020);
      chk("t5_c01_wrap", 64'(obs_addr[5]), 64'd0);
      finish_chk("t5");
      sel = 1'b0;
      // abort at the 10th emission, then restart
      build(2, 3, 2, 512);
      start_job(32'h0003_0202);
      run_stream(-1, 0, 9, 1'b0, nx, span);
      @(negedge clk);
      abort = 1'b0;
      chk("t6_abort_idle", 64'({sv, sd, sb}), 64'd0);
      chk("t6_abort_count", 64'(nx), 64'd10);
      @(negedge clk);
      chk("t6_no_done", 64'({sv, sd}), 64'd0);
      build(1, 1, 1, 512);
      start_job(32'h0001_0101);
      run_stream(-1, 0, -1, 1'b0, nx, span);
      chk("t6_restart_a", 64'(obs_addr[0]), 64'd2);
      finish_chk("t6");
      // reset at the 10th emission, then restart
      build(2, 3, 2, 512);
      start_job(32'h0003_0202);
      run_stream(-1, 0, 9, 1'b1, nx, span);
      @(negedge clk);
      rst_n = 1'b1;
      chk("t7_reset_state", 64'({v1, a1, t1, r1, c1, l1, b1, d1, e1}), 64'd0);
      build(1, 1, 1, 512);
      start_job(32'h0001_0101);
      run_stream(-1, 0, -1, 1'b0, nx, span);
      chk("t7_restart_a", 64'(obs_addr[0]), 64'd2);
      finish_chk("t7");
      // start and abort together in IDLE
      @(negedge clk);
      cfg = 32'h0001_0101;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      chk("t8_stay_idle", 64'({sb, sv}), 64'd0);
      @(negedge clk);
      chk("t8_no_valid", 64'({sb, sv}), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
